tag_lookup_sequencer: RTL and testbench



---
 rtl/tag_lookup_sequencer_pkg.sv | 21 ++
 rtl/tag_lookup_sequencer_if.sv | 43 ++++
 rtl/bitwise_comparator.sv | 18 +
 rtl/tag_lookup_sequencer.sv | 150 +++++++++++++++
 tb/tb_tag_lookup_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tag_lookup_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// tag_lookup_sequencer_pkg
// Shared definitions for the tag lookup sequencer: FSM state encoding and
// default sizing of tag, associativity and statistic counters.
// No ports (package).
// ---------------------------------------------------------------------------
package tag_lookup_sequencer_pkg;

   localparam int DEF_TAG_W = 8;
   localparam int DEF_WAYS  = 4;
   localparam int DEF_WAY_W = 2;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CMP  = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/tag_lookup_sequencer_if.sv
// ---------------------------------------------------------------------------
// tag_lookup_sequencer_if
// Bundles the request, response and tag-array read signals of the lookup
// sequencer.
//   slave  : the sequencer itself (takes requests, reads the tag array,
//            produces responses)
//   master : the surrounding system (cache front end plus tag array)
// Signals:
//   req_valid/req_ready/req_tag        lookup request handshake
//   tag_rd_en/tag_rd_way               tag array read strobe and way index
//   tag_rd_data/tag_rd_vld             stored tag and line valid, 1 cycle later
//   rsp_valid/rsp_ready/rsp_hit/rsp_way lookup result handshake
// ---------------------------------------------------------------------------
interface tag_lookup_sequencer_if
   import tag_lookup_sequencer_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W,
   parameter int WAY_W = DEF_WAY_W
) ();

   logic             req_valid;
   logic             req_ready;
   logic [TAG_W-1:0] req_tag;
   logic             tag_rd_en;
   logic [WAY_W-1:0] tag_rd_way;
   logic [TAG_W-1:0] tag_rd_data;
   logic             tag_rd_vld;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_hit;
   logic [WAY_W-1:0] rsp_way;

   modport slave (
      input  req_valid, req_tag, tag_rd_data, tag_rd_vld, rsp_ready,
      output req_ready, tag_rd_en, tag_rd_way, rsp_valid, rsp_hit, rsp_way
   );

   modport master (
      output req_valid, req_tag, tag_rd_data, tag_rd_vld, rsp_ready,
      input  req_ready, tag_rd_en, tag_rd_way, rsp_valid, rsp_hit, rsp_way
   );

endinterface

// File: rtl/bitwise_comparator.sv
// ---------------------------------------------------------------------------
// bitwise_comparator
// Combinational equality of two WIDTH-bit words.
// Ports:
//   in_0, in_1 : operands
//   eq         : 1 when every bit of in_0 equals the corresponding bit of in_1
// ---------------------------------------------------------------------------
module bitwise_comparator #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   output logic             eq
);

   assign eq = ~|(in_0 ^ in_1);

endmodule

// File: rtl/tag_lookup_sequencer.sv
// ---------------------------------------------------------------------------
// tag_lookup_sequencer
// Resolves one cache lookup at a time by walking the ways of a set in
// ascending order through a single shared tag comparator. Each way costs a
// read cycle (RD) and a compare cycle (CMP); the first valid matching way
// wins. Saturating hit/miss statistics count completed responses.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request / tag-array read / response signals (slave side)
//   stat_clr  : synchronous clear of both statistic counters
//   hit_cnt   : saturating count of hit responses
//   miss_cnt  : saturating count of miss responses
// ---------------------------------------------------------------------------
module tag_lookup_sequencer
   import tag_lookup_sequencer_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W,
   parameter int WAYS  = DEF_WAYS,
   parameter int WAY_W = DEF_WAY_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tag_lookup_sequencer_if.slave   bus,
   input  logic                    stat_clr,
   output logic [CNT_W-1:0]        hit_cnt,
   output logic [CNT_W-1:0]        miss_cnt
);

   state_t           state_q, state_d;
   logic [WAY_W-1:0] way_q;
   logic [TAG_W-1:0] tag_q;
   logic             hit_q;
   logic [WAY_W-1:0] hit_way_q;

   logic             req_ready;
   logic             tag_rd_en;
   logic             rsp_valid;
   logic             ld_req;
   logic             step_way;
   logic             ld_rsp;
   logic             eq;
   logic             match;
   logic             last_way;
   logic             rsp_hs;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   bitwise_comparator #(
      .WIDTH (TAG_W)
   ) u_cmp (
      .in_0 (tag_q),
      .in_1 (bus.tag_rd_data),
      .eq   (eq)
   );

   // An equal tag on an invalid line is not a hit.
   assign match    = eq & bus.tag_rd_vld;
   // Miss is decided on the last way before any increment, so way_q never wraps.
   assign last_way = (way_q == WAY_W'(WAYS - 1));
   assign rsp_hs   = rsp_valid & bus.rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      tag_rd_en = 1'b0;
      rsp_valid = 1'b0;
      ld_req    = 1'b0;
      step_way  = 1'b0;
      ld_rsp    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               ld_req  = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            tag_rd_en = 1'b1;
            state_d   = CMP;
         end
         CMP: begin
            if (match || last_way) begin
               ld_rsp  = 1'b1;
               state_d = RESP;
            end else begin
               step_way = 1'b1;
               state_d  = RD;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request tag is pure data: loaded on acceptance, never reset.
   always_ff @(posedge clk) begin
      if (ld_req) tag_q <= bus.req_tag;
   end

   // way_q doubles as tag_rd_way, so the read way holds between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         way_q     <= '0;
         hit_q     <= 1'b0;
         hit_way_q <= '0;
      end else begin
         if (ld_req)        way_q <= '0;
         else if (step_way) way_q <= way_q + WAY_W'(1);
         if (ld_rsp) begin
            hit_q     <= match;
            hit_way_q <= match ? way_q : '0;
         end
      end
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (stat_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rsp_hs) begin
         if (hit_q) hit_cnt  <= sat_inc(hit_cnt);
         else       miss_cnt <= sat_inc(miss_cnt);
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.tag_rd_en  = tag_rd_en;
   assign bus.tag_rd_way = way_q;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_hit    = hit_q;
   assign bus.rsp_way    = hit_way_q;

endmodule

// File: tb/tb_tag_lookup_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tag_lookup_sequencer
// Directed and randomized lookups against a reference model of the lookup
// rules (first valid matching way in ascending order, fixed per-way cost,
// saturating statistics). A small synchronous tag array model answers reads.
// ---------------------------------------------------------------------------
module tb_tag_lookup_sequencer;

   localparam int TAG_W   = 8;
   localparam int WAYS    = 4;
   localparam int WAY_W   = 2;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             stat_clr;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   tag_lookup_sequencer_if #(.TAG_W(TAG_W), .WAY_W(WAY_W)) bus ();

   tag_lookup_sequencer #(
      .TAG_W (TAG_W),
      .WAYS  (WAYS),
      .WAY_W (WAY_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .stat_clr (stat_clr),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [TAG_W-1:0] mem_tag [WAYS];
   logic             mem_vld [WAYS];
   logic [WAY_W-1:0] rd_log  [$];

   int n_checks = 0;
   int n_pass   = 0;
   int m_hit    = 0;
   int m_miss   = 0;

   // Tag array: data follows the strobe by one cycle; otherwise junk, so a
   // compare taken at the wrong time shows up.
   always @(posedge clk) begin
      if (bus.tag_rd_en) begin
         bus.tag_rd_data <= mem_tag[bus.tag_rd_way];
         bus.tag_rd_vld  <= mem_vld[bus.tag_rd_way];
      end else begin
         bus.tag_rd_data <= TAG_W'($urandom);
         bus.tag_rd_vld  <= 1'($urandom);
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.tag_rd_en) rd_log.push_back(bus.tag_rd_way);
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: first valid way holding the tag, searched in ascending order.
   task automatic ref_lookup(input logic [TAG_W-1:0] t, output bit hit,
                             output int way, output int lat, output int nrd);
      hit = 0; way = 0; lat = 2 * WAYS; nrd = WAYS;
      for (int i = 0; i < WAYS; i++) begin
         if (mem_vld[i] && mem_tag[i] == t) begin
            hit = 1; way = i; lat = 2 * i + 2; nrd = i + 1;
            return;
         end
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_req_ready"},  32'(bus.req_ready),  32'd1);
      check_val({pfx, "_tag_rd_en"},  32'(bus.tag_rd_en),  32'd0);
      check_val({pfx, "_tag_rd_way"}, 32'(bus.tag_rd_way), 32'd0);
      check_val({pfx, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
      check_val({pfx, "_rsp_hit"},    32'(bus.rsp_hit),    32'd0);
      check_val({pfx, "_rsp_way"},    32'(bus.rsp_way),    32'd0);
      check_val({pfx, "_hit_cnt"},    32'(hit_cnt),        32'd0);
      check_val({pfx, "_miss_cnt"},   32'(miss_cnt),       32'd0);
   endtask

   task automatic accept_req(input logic [TAG_W-1:0] t);
      int guard = 0;
      bus.req_tag   = t;
      bus.req_valid = 1'b1;
      while (!bus.req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check_val("accept_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [TAG_W-1:0] t, input int hold,
                            input bit clr_hs);
      bit e_hit;
      int e_way, e_lat, e_nrd, lat;
      ref_lookup(t, e_hit, e_way, e_lat, e_nrd);
      rd_log.delete();
      accept_req(t);
      check_val("busy_req_ready", 32'(bus.req_ready), 32'd0);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.rsp_valid && lat < 40);
      check_val("latency",  32'(lat),         32'(e_lat));
      check_val("rsp_hit",  32'(bus.rsp_hit), 32'(e_hit));
      check_val("rsp_way",  32'(bus.rsp_way), 32'(e_way));
      check_val("rd_count", 32'(rd_log.size()), 32'(e_nrd));
      for (int i = 0; i < rd_log.size(); i++)
         check_val("rd_way_order", 32'(rd_log[i]), 32'(i));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_val("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("hold_rsp_hit",   32'(bus.rsp_hit),   32'(e_hit));
         check_val("hold_rsp_way",   32'(bus.rsp_way),   32'(e_way));
         check_val("hold_req_ready", 32'(bus.req_ready), 32'd0);
         check_val("hold_hit_cnt",   32'(hit_cnt),       32'(m_hit));
         check_val("hold_miss_cnt",  32'(miss_cnt),      32'(m_miss));
      end
      bus.rsp_ready = 1'b1;
      stat_clr      = clr_hs;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      stat_clr      = 1'b0;
      if (clr_hs) begin
         m_hit = 0; m_miss = 0;
      end else if (e_hit) begin
         m_hit = (m_hit == CNT_MAX) ? CNT_MAX : m_hit + 1;
      end else begin
         m_miss = (m_miss == CNT_MAX) ? CNT_MAX : m_miss + 1;
      end
      check_val("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("post_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("post_hit_cnt",   32'(hit_cnt),       32'(m_hit));
      check_val("post_miss_cnt",  32'(miss_cnt),      32'(m_miss));
   endtask

   task automatic load_set(input logic [TAG_W-1:0] t0, t1, t2, t3,
                           input logic [3:0] v);
      mem_tag[0] = t0; mem_tag[1] = t1; mem_tag[2] = t2; mem_tag[3] = t3;
      for (int i = 0; i < WAYS; i++) mem_vld[i] = v[i];
   endtask

   initial begin
      rst_n         = 1'b0;
      stat_clr      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b0;
      load_set(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
      #3;
      check_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Hit in way 1, then a full miss.
      load_set(8'h11, 8'hAA, 8'h33, 8'h44, 4'hF);
      do_lookup(8'hAA, 0, 1'b0);
      do_lookup(8'h5C, 0, 1'b0);

      // Invalid way 0 holds the same tag: search continues to way 1.
      load_set(8'hAA, 8'hAA, 8'h00, 8'h00, 4'b1110);
      do_lookup(8'hAA, 0, 1'b0);

      // Response back-pressured for 5 cycles.
      load_set(8'h11, 8'hAA, 8'h33, 8'h44, 4'hF);
      do_lookup(8'h33, 5, 1'b0);

      // Reset during the compare of way 2.
      rd_log.delete();
      accept_req(8'h5C);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      check_val("mid_tag_rd_way", 32'(bus.tag_rd_way), 32'd2);
      rst_n = 1'b0;
      #1;
      m_hit = 0; m_miss = 0;
      check_reset_outputs("mid_reset");
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_lookup(8'h44, 0, 1'b0);

      // Randomized sets with narrow tag range to force duplicates.
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < WAYS; i++) begin
            mem_tag[i] = TAG_W'($urandom_range(0, 7));
            mem_vld[i] = ($urandom_range(0, 3) != 0);
         end
         do_lookup(TAG_W'($urandom_range(0, 8)), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0));
      end

      // Saturation of the hit counter, then clear against a hit.
      load_set(8'h11, 8'hAA, 8'h33, 8'h44, 4'hF);
      do_lookup(8'h11, 0, 1'b1);
      for (int n = 0; n < CNT_MAX; n++) do_lookup(8'h11, 0, 1'b0);
      check_val("sat_reached", 32'(hit_cnt), 32'(CNT_MAX));
      do_lookup(8'h44, 0, 1'b0);
      check_val("sat_hold", 32'(hit_cnt), 32'(CNT_MAX));
      do_lookup(8'h11, 1, 1'b1);
      check_val("clr_over_hit", 32'(hit_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
